// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared definitions for the RV32I instruction encoder.
//   - opcode constants for the formats the encoder understands
//   - fmt_e: instruction format selected from the opcode
//   - enc_entry_t: one buffered output word (instruction + error flag)
//   - NOP: word emitted for an unknown opcode (addi x0,x0,0)
//   - fmt_of(): opcode -> format decode
package instr_enc_pkg;

  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_OPIMM  = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_OP     = 7'd51;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_R,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_entry_t;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_OPIMM, OP_LOAD, OP_JALR: f = FMT_I;
      OP_STORE:                   f = FMT_S;
      OP_BRANCH:                  f = FMT_B;
      OP_LUI, OP_AUIPC:           f = FMT_U;
      OP_JAL:                     f = FMT_J;
      OP_OP:                      f = FMT_R;
      default:                    f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// instr_enc_fifo: 2-entry FIFO of enc_entry_t with read/write pointers and
// an occupancy count.
//   clk, rst    clock, async active-high reset
//   push        write push_entry at the tail (caller guarantees !full)
//   push_entry  entry to write
//   pop         drop the head (caller guarantees !empty)
//   full, empty occupancy flags
//   head_entry  current head; while empty, the last entry popped (0 after reset)
module instr_enc_fifo
  import instr_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  enc_entry_t push_entry,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output enc_entry_t head_entry
);

  enc_entry_t mem_q [2];
  enc_entry_t mem_d [2];
  enc_entry_t last_q, last_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  // Hold the last emitted word on the output once the buffer drains.
  assign head_entry = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      last_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I instruction encoder (I/S/B/U/J/R formats) with a
// 2-entry output buffer and a valid/ready interface on both sides.
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   request handshake (in_ready = buffer not full)
//   opcode, funct3, funct7, rd, rs1, rs2, imm   instruction fields
//   out_valid/out_ready encoded-word handshake
//   instr, err          encoded word and its fault flag (held while stalled
//                       and while empty)
//   enc_count           completed output handshakes, wraps
// Optional build macro INSTR_ENC_RANGE_CHK_EN: also flags immediates that do
// not fit the format (or are misaligned for B/J, or have low bits set for U).
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [D_WIDTH-1:0] imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] instr,
  output logic               err,
  output logic [CNT_W-1:0]   enc_count
);

  fmt_e       fmt;
  logic [31:0] word;
  logic       range_err;
  enc_entry_t push_entry;
  enc_entry_t head_entry;
  logic       full, empty, push, pop;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;

  assign fmt = fmt_of(opcode);

  always_comb begin
    word = NOP;
    case (fmt)
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      default: word = NOP;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHK_EN
  // A value fits an N-bit signed field when all bits from N-1 upward agree.
  logic fits12, fits13, fits21;
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_err = ~fits12;
      // Even alignment also excludes the odd top value of the signed field.
      FMT_B:        range_err = ~fits13 | imm[0];
      FMT_J:        range_err = ~fits21 | imm[0];
      FMT_U:        range_err = |imm[11:0];
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign push_entry.instr = word;
  assign push_entry.err   = (fmt == FMT_BAD) | range_err;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = ~empty & out_ready;

  instr_enc_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head_entry (head_entry)
  );

  assign instr = head_entry.instr;
  assign err   = head_entry.err;

  always_comb begin
    enc_count_d = enc_count_q;
    if (pop) enc_count_d = enc_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) enc_count_q <= '0;
    else     enc_count_q <= enc_count_d;
  end

  assign enc_count = enc_count_q;

endmodule
